// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS debug run controller.
// The command bytes here are defaults; the top module can override them with parameters.
package mips_dbg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CPU_RST,
    LOAD_CNT,
    LOAD_DATA,
    LOAD_WR,
    RUN,
    STEP,
    DUMP,
    ACK
  } dbg_state_e;

  localparam logic [7:0] DEF_CMD_LOAD = 8'h4C;
  localparam logic [7:0] DEF_CMD_CONT = 8'h43;
  localparam logic [7:0] DEF_CMD_STEP = 8'h53;
  localparam logic [7:0] DEF_CMD_RST  = 8'h52;

  localparam logic [7:0] STAT_HALT  = 8'h00;
  localparam logic [7:0] STAT_STEP  = 8'h01;
  localparam logic [7:0] STAT_LIMIT = 8'h02;
  localparam logic [7:0] ACK_BYTE   = 8'h06;

  localparam int DUMP_BYTES = 133;

  // Byte sel of a word, sel 0 being the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dbg_tx_serializer.sv
// Streams either the single ack byte or the 133-byte status/PC/register dump to the host.
// The byte index only moves on a transfer, so the output byte stays stable while the sink stalls.
module dbg_tx_serializer
  import mips_dbg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        ack_i,
  input  logic [7:0]  status_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] reg_data_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic [4:0]  reg_addr_o,
  output logic        done_o
);

  localparam logic [7:0] LastIdx = 8'(DUMP_BYTES - 1);

  logic        active_q, active_d;
  logic        ack_q, ack_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  status_q, status_d;
  logic [31:0] pc_q, pc_d;

  logic [6:0]  regOff;
  logic [1:0]  pcSel;
  logic        lastByte;
  logic        xfer;

  always_comb begin
    // Index 5 onwards maps to r0 byte 0; the 7-bit wrap keeps index 132 at offset 127.
    regOff   = idx_q[6:0] - 7'd5;
    pcSel    = idx_q[1:0] - 2'd1;
    xfer     = active_q & tx_ready_i;
    lastByte = ack_q | (idx_q == LastIdx);

    tx_valid_o = active_q;
    tx_data_o  = 8'h00;
    reg_addr_o = 5'd0;
    if (active_q) begin
      if (ack_q) begin
        tx_data_o = ACK_BYTE;
      end else if (idx_q == 8'd0) begin
        tx_data_o = status_q;
      end else if (idx_q < 8'd5) begin
        tx_data_o = word_byte(pc_q, pcSel);
      end else begin
        reg_addr_o = regOff[6:2];
        tx_data_o  = word_byte(reg_data_i, regOff[1:0]);
      end
    end
    done_o = xfer & lastByte;
  end

  always_comb begin
    active_d = active_q;
    ack_d    = ack_q;
    idx_d    = idx_q;
    status_d = status_q;
    pc_d     = pc_q;
    if (start_i) begin
      active_d = 1'b1;
      ack_d    = ack_i;
      idx_d    = 8'd0;
      status_d = status_i;
    end else if (active_q) begin
      // PC is captured during the status byte, once the CPU is frozen.
      if (!ack_q && idx_q == 8'd0) pc_d = pc_i;
      if (xfer) begin
        idx_d = idx_q + 8'd1;
        if (lastByte) active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      ack_q    <= 1'b0;
      idx_q    <= 8'd0;
      status_q <= 8'h00;
      pc_q     <= 32'h0;
    end else begin
      active_q <= active_d;
      ack_q    <= ack_d;
      idx_q    <= idx_d;
      status_q <= status_d;
      pc_q     <= pc_d;
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Host byte-stream run controller for the MIPS pipeline: loads instruction memory,
// runs or single-steps the CPU via a clock enable, then dumps status, PC and registers.
module mips_debug_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int         IMEM_AW    = 8,
  parameter int         MAX_CYCLES = 1024,
  parameter logic [7:0] CMD_LOAD   = DEF_CMD_LOAD,
  parameter logic [7:0] CMD_CONT   = DEF_CMD_CONT,
  parameter logic [7:0] CMD_STEP   = DEF_CMD_STEP,
  parameter logic [7:0] CMD_RST    = DEF_CMD_RST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_imem_wr_en,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [31:0]        o_imem_data,
  output logic               o_cpu_en,
  output logic               o_cpu_rst,
  input  logic               i_cpu_halt,
  input  logic [31:0]        i_pc,
  output logic [4:0]         o_reg_addr,
  input  logic [31:0]        i_reg_data,
  output logic               o_busy
);

  localparam int             CW       = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0]  CycLimit = CW'(MAX_CYCLES);

  dbg_state_e          state_q, state_d;
  logic [7:0]          wordCnt_q, wordCnt_d;
  logic [1:0]          byteCnt_q, byteCnt_d;
  logic [IMEM_AW-1:0]  addr_q, addr_d;
  logic [31:0]         word_q, word_d;
  logic [CW-1:0]       cyc_q, cyc_d;

  logic                serStart;
  logic                serAck;
  logic [7:0]          serStatus;
  logic                serDone;

  always_comb begin
    state_d      = state_q;
    wordCnt_d    = wordCnt_q;
    byteCnt_d    = byteCnt_q;
    addr_d       = addr_q;
    word_d       = word_q;
    cyc_d        = cyc_q;
    o_imem_wr_en = 1'b0;
    o_cpu_en     = 1'b0;
    o_cpu_rst    = 1'b0;
    serStart     = 1'b0;
    serAck       = 1'b0;
    serStatus    = STAT_HALT;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_RST) begin
            state_d = CPU_RST;
          end else if (i_rx_data == CMD_LOAD) begin
            state_d = LOAD_CNT;
          end else if (i_rx_data == CMD_CONT) begin
            cyc_d   = '0;
            state_d = RUN;
          end else if (i_rx_data == CMD_STEP) begin
            state_d = STEP;
          end
        end
      end
      CPU_RST: begin
        o_cpu_rst = 1'b1;
        state_d   = IDLE;
      end
      LOAD_CNT: begin
        if (i_rx_valid) begin
          if (i_rx_data == 8'd0) begin
            serStart = 1'b1;
            serAck   = 1'b1;
            state_d  = ACK;
          end else begin
            wordCnt_d = i_rx_data;
            byteCnt_d = 2'd0;
            addr_d    = '0;
            state_d   = LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        if (i_rx_valid) begin
          word_d    = {word_q[23:0], i_rx_data};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) state_d = LOAD_WR;
        end
      end
      LOAD_WR: begin
        o_imem_wr_en = 1'b1;
        addr_d       = addr_q + 1'b1;
        wordCnt_d    = wordCnt_q - 8'd1;
        if (wordCnt_q == 8'd1) begin
          serStart = 1'b1;
          serAck   = 1'b1;
          state_d  = ACK;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      RUN: begin
        // Halt gates the enable combinationally so no extra cycle slips through.
        if (i_cpu_halt) begin
          serStart  = 1'b1;
          serStatus = STAT_HALT;
          state_d   = DUMP;
        end else if (cyc_q >= CycLimit) begin
          serStart  = 1'b1;
          serStatus = STAT_LIMIT;
          state_d   = DUMP;
        end else begin
          o_cpu_en = 1'b1;
          cyc_d    = cyc_q + 1'b1;
        end
      end
      STEP: begin
        serStart = 1'b1;
        state_d  = DUMP;
        if (!i_cpu_halt) begin
          o_cpu_en  = 1'b1;
          serStatus = STAT_STEP;
        end
      end
      DUMP, ACK: begin
        if (serDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wordCnt_q <= 8'd0;
      byteCnt_q <= 2'd0;
      addr_q    <= '0;
      word_q    <= 32'h0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      byteCnt_q <= byteCnt_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      cyc_q     <= cyc_d;
    end
  end

  assign o_imem_addr = addr_q;
  assign o_imem_data = word_q;
  assign o_busy      = (state_q != IDLE);

  dbg_tx_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .start_i    (serStart),
    .ack_i      (serAck),
    .status_i   (serStatus),
    .pc_i       (i_pc),
    .reg_data_i (i_reg_data),
    .tx_ready_i (i_tx_ready),
    .tx_data_o  (o_tx_data),
    .tx_valid_o (o_tx_valid),
    .reg_addr_o (o_reg_addr),
    .done_o     (serDone)
  );

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: a scoreboard queue of expected host bytes,
// a table of IDLE command vectors, and directed load/run/step/reset sequences.
module tb_mips_debug_ctrl;

  localparam int MaxCyc = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        wrEn;
  logic [7:0]  imemAddr;
  logic [31:0] imemData;
  logic        cpuEn;
  logic        cpuRst;
  logic        cpuHalt;
  logic [31:0] pcVal = 32'h0;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        busy;

  int nChecks = 0;
  int nErrors = 0;
  logic [7:0]  expQ[$];
  logic [31:0] imemModel [256];
  int txCount = 0, wrCount = 0, enObs = 0, rstObs = 0;
  int cycleNo = 0, lastTxCycle = 0, idleCycle = 0;
  int enCnt = 0, haltBase = 0, haltLimit = 0;
  bit haltLevel = 0, regPattern = 0, readyRandom = 0, holdReady = 0;
  bit stallPending = 0;
  logic [7:0] heldData = 8'h00;

  typedef struct {
    logic [7:0] rx;
    logic       expBusy;
    int         expRst;
  } idleVec_t;
  idleVec_t vecs[5];

  always #5 clk = ~clk;

  function automatic logic [31:0] regVal(input logic [4:0] a, input bit pat);
    return pat ? {a ^ 5'h15, 3'b101, 8'hC3, 3'b000, a, ~{3'b000, a}} : {27'b0, a};
  endfunction

  assign regData = regVal(regAddr, regPattern);
  assign cpuHalt = haltLevel || (haltLimit != 0 && (enCnt - haltBase) >= haltLimit);

  mips_debug_ctrl #(
    .IMEM_AW    (8),
    .MAX_CYCLES (MaxCyc)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (rxData),
    .i_rx_valid   (rxValid),
    .o_tx_data    (txData),
    .o_tx_valid   (txValid),
    .i_tx_ready   (txReady),
    .o_imem_wr_en (wrEn),
    .o_imem_addr  (imemAddr),
    .o_imem_data  (imemData),
    .o_cpu_en     (cpuEn),
    .o_cpu_rst    (cpuRst),
    .i_cpu_halt   (cpuHalt),
    .i_pc         (pcVal),
    .o_reg_addr   (regAddr),
    .i_reg_data   (regData),
    .o_busy       (busy)
  );

  // Pipeline model: counts enabled cycles, which drives the programmable halt.
  always @(posedge clk) begin
    cycleNo <= cycleNo + 1;
    if (cpuEn) enCnt <= enCnt + 1;
  end

  always @(posedge clk) begin
    #1;
    txReady = holdReady ? 1'b0 : (readyRandom ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stallPending && txValid) checkOutput("tx_hold", {24'h0, txData}, {24'h0, heldData});
    stallPending = txValid && (txReady === 1'b0);
    heldData = txData;
    if (txValid) checkOutput("cpu_en_during_tx", {31'h0, cpuEn}, 32'h0);
    if (txValid && txReady === 1'b1) begin
      txCount++;
      lastTxCycle = cycleNo;
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL tx_unexpected: got %0h, expected no byte", txData);
      end else begin
        checkOutput("tx_byte", {24'h0, txData}, {24'h0, expQ.pop_front()});
      end
    end
    if (wrEn) begin
      imemModel[imemAddr] = imemData;
      wrCount++;
    end
    if (cpuEn) enObs++;
    if (cpuRst) rstObs++;
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    rxData  = b;
    rxValid = 1'b1;
    @(posedge clk); #1;
    rxValid = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] w);
    expQ.push_back(w[31:24]);
    expQ.push_back(w[23:16]);
    expQ.push_back(w[15:8]);
    expQ.push_back(w[7:0]);
  endtask

  task automatic pushDump(input logic [7:0] status, input logic [31:0] pc);
    expQ.push_back(status);
    pushWord(pc);
    for (int i = 0; i < 32; i++) pushWord(regVal(5'(i), regPattern));
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    idleCycle = cycleNo;
    if (!ok) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL %s_timeout: got busy after %0d cycles, expected idle", name, budget);
    end
    checkOutput({name, "_sb_empty"}, expQ.size(), 0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_tx"}, {22'h0, txValid, txData, regAddr}, 32'h0);
    checkOutput({name, "_imem"}, {23'h0, wrEn, imemAddr}, 32'h0);
    checkOutput({name, "_imem_data"}, imemData, 32'h0);
    checkOutput({name, "_cpu"}, {29'h0, cpuEn, cpuRst, busy}, 32'h0);
  endtask

  initial begin : main
    int base;
    logic [31:0] loadWords[2];
    vecs[0] = '{8'h00, 1'b0, 0};
    vecs[1] = '{8'hFF, 1'b0, 0};
    vecs[2] = '{8'h41, 1'b0, 0};
    vecs[3] = '{8'h52, 1'b1, 1};
    vecs[4] = '{8'h06, 1'b0, 0};
    loadWords[0] = 32'h20010005;
    loadWords[1] = 32'hAC010000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Command bytes seen in IDLE: unknown ones dropped, 'R' pulses the CPU reset once.
    for (int v = 0; v < 5; v++) begin
      base = rstObs;
      applyStimulus(vecs[v].rx);
      @(negedge clk);
      checkOutput("idle_busy", {31'h0, busy}, {31'h0, vecs[v].expBusy});
      repeat (3) @(negedge clk);
      checkOutput("idle_rst_pulses", rstObs - base, vecs[v].expRst);
      checkOutput("idle_back", {31'h0, busy}, 32'h0);
    end

    // Two-word load followed by the ack byte.
    base = wrCount;
    expQ.push_back(8'h06);
    applyStimulus(8'h4C);
    applyStimulus(8'h02);
    for (int w = 0; w < 2; w++)
      for (int b = 3; b >= 0; b--) applyStimulus(loadWords[w][b*8 +: 8]);
    waitIdle("load2", 200);
    checkOutput("load_wr_count", wrCount - base, 2);
    checkOutput("imem0", imemModel[0], 32'h20010005);
    checkOutput("imem1", imemModel[1], 32'hAC010000);

    // Zero-length load: only the ack, no writes.
    base = wrCount;
    expQ.push_back(8'h06);
    applyStimulus(8'h4C);
    applyStimulus(8'h00);
    waitIdle("load0", 200);
    checkOutput("load0_wr_count", wrCount - base, 0);

    // A new load restarts at address 0.
    base = wrCount;
    expQ.push_back(8'h06);
    applyStimulus(8'h4C);
    applyStimulus(8'h01);
    applyStimulus(8'hDE); applyStimulus(8'hAD); applyStimulus(8'hBE); applyStimulus(8'hEF);
    waitIdle("load1", 200);
    checkOutput("reload_wr_count", wrCount - base, 1);
    checkOutput("reload_imem0", imemModel[0], 32'hDEADBEEF);
    checkOutput("reload_imem1", imemModel[1], 32'hAC010000);

    // Single step with r[i]=i.
    pcVal = 32'h4;
    base = enObs;
    pushDump(8'h01, 32'h4);
    applyStimulus(8'h53);
    waitIdle("step", 1000);
    checkOutput("step_en_cycles", enObs - base, 1);
    checkOutput("step_idle_timing", idleCycle, lastTxCycle + 1);

    // Continuous run halting after 10 enabled cycles.
    regPattern = 1;
    pcVal = 32'h0000_0028;
    base = enObs;
    haltBase = enCnt;
    haltLimit = 10;
    pushDump(8'h00, 32'h0000_0028);
    applyStimulus(8'h43);
    waitIdle("cont_halt", 1000);
    checkOutput("cont_halt_en_cycles", enObs - base, 10);
    haltLimit = 0;

    // Watchdog limit.
    pcVal = 32'h0000_1040;
    base = enObs;
    pushDump(8'h02, 32'h0000_1040);
    applyStimulus(8'h43);
    waitIdle("cont_limit", 1000);
    checkOutput("cont_limit_en_cycles", enObs - base, MaxCyc);
    checkOutput("cont_limit_idle_timing", idleCycle, lastTxCycle + 1);

    // Already halted: zero enabled cycles for both run and step.
    haltLevel = 1;
    base = enObs;
    pushDump(8'h00, 32'h0000_1040);
    applyStimulus(8'h43);
    waitIdle("cont_halted", 1000);
    pushDump(8'h00, 32'h0000_1040);
    applyStimulus(8'h53);
    waitIdle("step_halted", 1000);
    checkOutput("halted_en_cycles", enObs - base, 0);
    haltLevel = 0;

    // Dump under a randomly stalling sink.
    readyRandom = 1;
    pcVal = 32'h0040_1234;
    base = enObs;
    pushDump(8'h01, 32'h0040_1234);
    applyStimulus(8'h53);
    waitIdle("step_stall", 3000);
    checkOutput("stall_en_cycles", enObs - base, 1);
    readyRandom = 0;

    // Reset in the middle of a dump, then a CPU reset command.
    base = txCount;
    pushDump(8'h01, 32'h0040_1234);
    applyStimulus(8'h53);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (txCount - base >= 20) break;
    end
    checkOutput("middump_progress", 32'(txCount - base >= 20), 32'h1);
    holdReady = 1;
    @(posedge clk); #1;
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    checkAllZero("middump_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    holdReady = 0;
    base = rstObs;
    applyStimulus(8'h52);
    repeat (4) @(negedge clk);
    checkOutput("post_reset_rst_pulses", rstObs - base, 1);
    checkOutput("post_reset_idle", {31'h0, busy}, 32'h0);
    checkOutput("post_reset_sb_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
- Byte-stream run controller for the MIPS pipeline.
- Loads program words into instruction memory, releases the CPU in continuous or single-step mode via a clock enable, and waits for halt or a watchdog limit.
- After each run or step, streams a status byte, the PC and all 32 registers back out.
- Sits between a host byte link (UART wrapper) and the MIPS top, beside the pipeline rather than inside it.

Parameters:
- IMEM_AW, 8, instruction-memory word-address width.
- MAX_CYCLES, 1024, watchdog limit on enabled CPU cycles per continuous run.
- CMD_LOAD, 8'h4C, load command byte ('L').
- CMD_CONT, 8'h43, continuous-run command byte ('C').
- CMD_STEP, 8'h53, single-step command byte ('S').
- CMD_RST, 8'h52, CPU-reset command byte ('R').

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received host byte.
- i_rx_valid  in  1  one-cycle strobe per received byte; no backpressure.
- o_tx_data  out  8  byte to host.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  sink accepts the byte this cycle.
- o_imem_wr_en  out  1  instruction-memory write strobe.
- o_imem_addr  out  IMEM_AW  instruction-memory word address.
- o_imem_data  out  32  instruction word.
- o_cpu_en  out  1  pipeline clock enable.
- o_cpu_rst  out  1  one-cycle CPU reset pulse.
- i_cpu_halt  in  1  pipeline has retired HALT (level).
- i_pc  in  32  current PC.
- o_reg_addr  out  5  register-file debug read address.
- i_reg_data  in  32  register-file data; combinational read, valid in the same cycle.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: every output 0; FSM goes to IDLE; the word counter, byte counter and address counter clear. Reset applied mid-operation aborts it, and a partial load leaves the words already written in memory.
- IDLE: acts only on i_rx_valid. Unknown command bytes are dropped.
  - CMD_RST -> CPU_RST (o_cpu_rst=1 for exactly one cycle) -> IDLE.
  - CMD_LOAD -> LOAD_CNT.
  - CMD_CONT -> RUN.
  - CMD_STEP -> STEP.
- LOAD_CNT: the next byte is word count N.
  - N=0: send only the ack byte 8'h06, then IDLE.
  - Otherwise clear the address counter and go to LOAD_DATA.
- LOAD_DATA: assembles 4 bytes MSB-first into a word.
  - On the 4th byte, the next cycle pulses o_imem_wr_en with o_imem_addr=address counter and o_imem_data=word.
  - The address then increments and wraps mod 2^IMEM_AW.
  - After N words, send ack 8'h06, then IDLE.
- RUN:
  - o_cpu_en=1 each cycle while i_cpu_halt=0 and the enabled-cycle count is < MAX_CYCLES.
  - Halt observed: o_cpu_en drops in the same cycle (combinational gate) -> DUMP with status 8'h00.
  - Limit reached -> DUMP with status 8'h02.
  - i_cpu_halt already high on entry -> zero enabled cycles, status 8'h00.
- STEP: o_cpu_en=1 for exactly one cycle, or zero cycles if already halted. Then DUMP with status 8'h01, or 8'h00 if halted.
- DUMP: 133 bytes in this order:
  - status byte;
  - PC, 4 bytes MSB-first, latched on DUMP entry;
  - r0..r31, 4 bytes each MSB-first.
  - o_reg_addr = register index for the current byte; o_cpu_en=0 throughout.
  - A byte transfers when o_tx_valid & i_tx_ready; o_tx_data is held stable while valid and not ready.
  - After the final transfer -> IDLE.
- i_rx_valid bytes received in any state other than IDLE, LOAD_CNT or LOAD_DATA are dropped.
- The cycle counter is wide enough for MAX_CYCLES and clears on each RUN entry.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - FSM state enum: IDLE, CPU_RST, LOAD_CNT, LOAD_DATA, LOAD_WR, RUN, STEP, DUMP, ACK.
  - Command byte constants.
  - Status codes 8'h00, 8'h01, 8'h02 and ACK 8'h06.
  - DUMP_BYTES=133.
- One natural sub-module, dbg_tx_serializer: byte-index counter, word/byte select and valid/ready hold logic used for both DUMP and ACK.

Test Plan:
- 'L', 8'h02, 20 01 00 05, AC 01 00 00 -> imem[0]=32'h20010005, imem[1]=32'hAC010000, one wr_en pulse each; then tx 8'h06.
- 'S' with i_pc=32'h4 and r[i]=i -> o_cpu_en high exactly 1 cycle; tx 01, 00 00 00 04, then 00 00 00 00, 00 00 00 01 ... 00 00 00 1F (133 bytes).
- 'C' with i_cpu_halt rising after 10 enabled cycles -> exactly 10 o_cpu_en cycles; first tx byte 8'h00.
- 'C' with MAX_CYCLES=16 and halt never asserted -> 16 enabled cycles; status 8'h02; o_busy low after byte 133.
- DUMP with i_tx_ready toggling randomly -> byte sequence identical to the ready=1 case; o_tx_data stable while stalled.
- rst asserted mid-DUMP -> next cycle all outputs 0 and FSM in IDLE; then 'R' -> o_cpu_rst high exactly 1 cycle.
